// File: rtl/fp_norm_pkg.sv
// Shared types and sizing helpers for the post-add normalizer.
package fp_norm_pkg;

   localparam int MANT_W_DEF = 24;
   localparam int EXP_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } norm_state_e;

   // Number of binary left-shift stages needed to cover a mantissa of this width.
   function automatic int nstage(input int mant_w);
      return $clog2(mant_w);
   endfunction

   // Width of the stage counter; at least one bit even for a single stage.
   function automatic int k_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/norm_shift_left_if.sv
// Input and output handshake bundle of the normalizer.
interface norm_shift_left_if
   import fp_norm_pkg::*;
#(
   parameter int MANT_W = MANT_W_DEF,
   parameter int EXP_W  = EXP_W_DEF
);
   logic              in_valid;
   logic              in_ready;
   logic [MANT_W:0]   in;
   logic [EXP_W-1:0]  in_exp;

   logic              out_valid;
   logic              out_ready;
   logic [MANT_W-1:0] out;
   logic [EXP_W-1:0]  out_exp;
   logic              out_guard;
   logic              out_zero;
   logic              out_denorm;
   logic              out_ovf;

   modport master (
      output in_valid, in, in_exp, out_ready,
      input  in_ready, out_valid, out, out_exp,
             out_guard, out_zero, out_denorm, out_ovf
   );

   modport slave (
      input  in_valid, in, in_exp, out_ready,
      output in_ready, out_valid, out, out_exp,
             out_guard, out_zero, out_denorm, out_ovf
   );
endinterface

// File: rtl/norm_shift_left_stage.sv
// One left-shift stage of the leading-zero search. Always produces the shifted
// mantissa and reduced exponent; taken_o tells the caller whether to use them.
module norm_stage_left
   import fp_norm_pkg::*;
#(
   parameter int MANT_W = MANT_W_DEF,
   parameter int EXP_W  = EXP_W_DEF,
   parameter int K_W    = 3
) (
   input  logic [MANT_W-1:0] m_i,
   input  logic [EXP_W:0]    e_i,
   input  logic [K_W-1:0]    k_i,
   output logic [MANT_W-1:0] m_o,
   output logic [EXP_W:0]    e_o,
   output logic              taken_o
);

   logic [EXP_W:0]    s;
   logic [MANT_W-1:0] top_mask;

   // Shift by 2^k only if the top 2^k bits are clear and the exponent stays >= 1.
   always_comb begin
      s        = (EXP_W+1)'(1) << k_i;
      top_mask = ~({MANT_W{1'b1}} >> s);
      m_o      = m_i << s;
      e_o      = e_i - s;
      taken_o  = ((m_i & top_mask) == '0) && (e_i > s);
   end

endmodule

// File: rtl/norm_shift_left.sv
// Post-add normalizer: carry right-shift or iterative 16/8/4/2/1 left-shift
// with exponent clamp, between the adder and the rounding stage.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a raw sum
// SHIFT | one leading-zero stage per cycle, k counts down to 0
// DONE  | out_valid=1, result held until out_ready
module norm_shift_left
   import fp_norm_pkg::*;
#(
   parameter int MANT_W = MANT_W_DEF,
   parameter int EXP_W  = EXP_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   norm_shift_left_if.slave  bus
);

   localparam int NSTAGE = nstage(MANT_W);
   localparam int K_W    = k_width(NSTAGE);
   localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

   norm_state_e       state_q, state_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [MANT_W-1:0] m_q, m_d;
   logic [EXP_W:0]    e_q, e_d;
   logic [MANT_W-1:0] out_q, out_d;
   logic [EXP_W-1:0]  out_exp_q, out_exp_d;
   logic              guard_q, guard_d;
   logic              zero_q, zero_d;
   logic              denorm_q, denorm_d;
   logic              ovf_q, ovf_d;

   logic [MANT_W-1:0] stg_m;
   logic [EXP_W:0]    stg_e;
   logic              stg_taken;
   logic [MANT_W-1:0] shf_m;
   logic [EXP_W:0]    shf_e;
   logic [EXP_W:0]    e_in;
   logic [EXP_W:0]    e_inc;

   norm_stage_left #(
      .MANT_W (MANT_W),
      .EXP_W  (EXP_W),
      .K_W    (K_W)
   ) u_stage (
      .m_i     (m_q),
      .e_i     (e_q),
      .k_i     (k_q),
      .m_o     (stg_m),
      .e_o     (stg_e),
      .taken_o (stg_taken)
   );

   // State register and result registers; reset discards any in-flight result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         k_q       <= '0;
         m_q       <= '0;
         e_q       <= '0;
         out_q     <= '0;
         out_exp_q <= '0;
         guard_q   <= 1'b0;
         zero_q    <= 1'b0;
         denorm_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         m_q       <= m_d;
         e_q       <= e_d;
         out_q     <= out_d;
         out_exp_q <= out_exp_d;
         guard_q   <= guard_d;
         zero_q    <= zero_d;
         denorm_q  <= denorm_d;
         ovf_q     <= ovf_d;
      end
   end

   // Next-state and datapath: classify on accept, step the shifter, finalize.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      m_d       = m_q;
      e_d       = e_q;
      out_d     = out_q;
      out_exp_d = out_exp_q;
      guard_d   = guard_q;
      zero_d    = zero_q;
      denorm_d  = denorm_q;
      ovf_d     = ovf_q;

      // Exponent 0 still allows shifting down to 1 before going subnormal.
      e_in  = (bus.in_exp == '0) ? (EXP_W+1)'(1) : {1'b0, bus.in_exp};
      e_inc = e_in + (EXP_W+1)'(1);
      shf_m = stg_taken ? stg_m : m_q;
      shf_e = stg_taken ? stg_e : e_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               out_d     = '0;
               out_exp_d = '0;
               guard_d   = 1'b0;
               zero_d    = 1'b0;
               denorm_d  = 1'b0;
               ovf_d     = 1'b0;
               if (bus.in[MANT_W]) begin
                  m_d     = bus.in[MANT_W:1];
                  e_d     = e_inc;
                  out_d   = bus.in[MANT_W:1];
                  guard_d = bus.in[0];
                  if (e_inc >= EXP_MAX) begin
                     ovf_d     = 1'b1;
                     out_exp_d = EXP_MAX[EXP_W-1:0];
                  end else begin
                     out_exp_d = e_inc[EXP_W-1:0];
                  end
                  state_d = DONE;
               end else if (bus.in[MANT_W-1:0] == '0) begin
                  m_d     = '0;
                  e_d     = '0;
                  zero_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  m_d     = bus.in[MANT_W-1:0];
                  e_d     = e_in;
                  k_d     = K_W'(NSTAGE - 1);
                  state_d = SHIFT;
               end
            end
         end

         SHIFT: begin
            m_d = shf_m;
            e_d = shf_e;
            if (k_q == '0) begin
               out_d = shf_m;
               if (shf_m[MANT_W-1]) begin
                  out_exp_d = shf_e[EXP_W-1:0];
               end else begin
                  out_exp_d = '0;
                  denorm_d  = 1'b1;
               end
               state_d = DONE;
            end else begin
               k_d = k_q - K_W'(1);
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.out        = out_q;
   assign bus.out_exp    = out_exp_q;
   assign bus.out_guard  = guard_q;
   assign bus.out_zero   = zero_q;
   assign bus.out_denorm = denorm_q;
   assign bus.out_ovf    = ovf_q;

endmodule

// File: doc/norm_shift_left.md
# norm_shift_left

Sequential post-add normalizer for the FP adder datapath. It accepts the 25-bit raw mantissa sum (bit 24 = carry) plus the working exponent. The result is a normalized 24-bit mantissa and a corrected exponent.
- Carry-out case: one right shift.
- Otherwise: leading zeros are removed by an iterative 16/8/4/2/1 left-shift search, one stage per cycle, clamped so the result never drops below minimum exponent (subnormal).
- Sits between the alignment/add stage and rounding, with valid/ready handshakes on both sides.

## Interface
- MANT_W, 24, mantissa width excluding carry bit
- EXP_W, 8, exponent width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input transfer request
- in_ready  out  1  block can accept (IDLE only)
- in  in  MANT_W+1  raw sum, bit MANT_W = carry
- in_exp  in  EXP_W  working exponent (0 treated as 1 for shift limit)
- out_valid  out  1  result available, held until taken
- out_ready  in  1  downstream accepts
- out  out  MANT_W  normalized mantissa
- out_exp  out  EXP_W  result exponent (0 = subnormal/zero)
- out_guard  out  1  bit dropped by carry right-shift, else 0
- out_zero, out_denorm, out_ovf  out  1 each  status flags

## Operation
- FSM states: IDLE, SHIFT, DONE. Stage counter k runs NSTAGE-1 down to 0, with NSTAGE = $clog2(MANT_W) (5 at default).
- IDLE, accept on in_valid & in_ready. The captured mantissa is m and the exponent is e, with e = max(in_exp, 1).
  - in[MANT_W]=1: m = in >> 1 and out_guard = in[0]; e = e+1. If e+1 = all-ones, out_ovf=1. Next state DONE.
  - in = 0: out = 0, out_exp = 0, out_zero = 1. Next state DONE.
  - Otherwise: next state SHIFT with k = NSTAGE-1.
- SHIFT, stage k with s = 2^k:
  - If the top s bits of m are 0 and e > s: m <<= s and e -= s. Otherwise m and e hold.
  - When k = 0, go to DONE; otherwise k-1.
- On entering DONE from SHIFT:
  - If m[MANT_W-1] = 0: out_exp = 0 and out_denorm = 1.
  - Otherwise: out_exp = e.
- DONE: out_valid = 1. On out_valid & out_ready, go to IDLE. No accept is possible in the same cycle.
- Arithmetic: exponent math is EXP_W+1 bits internally. out_ovf saturates out_exp to all-ones.
- Simultaneous events: none possible, because input and output handshakes are state-exclusive.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - out = 0, out_exp = 0, all flags = 0.
- Reset mid-operation (SHIFT or DONE): next cycle is IDLE and the in-flight result is discarded.
- Latency from the accept edge to out_valid high:
  - 1 cycle for carry or zero inputs.
  - NSTAGE+1 cycles (6 at default) for the shift path.
- Throughput is one result per latency+1 cycles minimum.
- Outputs are registered and stable while out_valid=1 & out_ready=0.
- in_ready is low from the cycle after an accept until the cycle after the output handshake.

## Structure
- Package fp_norm_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - MANT_W/EXP_W defaults;
  - the NSTAGE function.
- Sub-module norm_stage_left is combinational and is instantiated once, driven by the current k. It computes:
  - inputs m, e, k;
  - outputs shifted m, decremented e, and a shift-taken bit.

## Test plan
- in=25'h0800000, in_exp=127 -> out=24'h800000, out_exp=127, flags 0, out_valid 6 cycles after accept.
- in=25'h0000001, in_exp=127 -> out=24'h800000, out_exp=104 (shift 23).
- in=25'h1800001, in_exp=127 -> out=24'hC00000, out_exp=128, out_guard=1, latency 1.
- in=25'h1000000, in_exp=254 -> out_exp=255, out=24'h800000, out_ovf=1.
- in=25'h0000100, in_exp=10 -> shifts 8 then 1: out=24'h020000, out_exp=0, out_denorm=1.
- in=0, in_exp=100 -> out_zero=1, out_exp=0, latency 1. Hold out_ready=0 for 3 cycles -> outputs stable. Assert rst during SHIFT -> next cycle IDLE, out_valid=0, in_ready=1.
